regbank: RTL and testbench
==========================

Name: regbank

Overview:
- Parametrised successor to the fixed three-register bank.
- Holds NREGS configurable registers of DATAW bits behind a request/acknowledge bus port.
- Decodes the full address and flags out-of-range accesses with an error.
- Exports every register in parallel, plus a per-register write pulse and a registered XOR reduction.
- Sits between the bus mux slave port and datapath control logic.

Parameters:
- DATAW, 32, register and data width in bits; multiple of 8 when REGBANK_WSTRB_EN is defined.
- NREGS, 4, number of registers; 1..2**ADDRW.
- ADDRW, 8, address width.
- RST_VAL, 0, reset value loaded into every register (DATAW bits).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  access request; sampled every cycle.
- i_we  in  1  1 = write, 0 = read; qualified by i_req.
- i_addr  in  ADDRW  register index (word address).
- i_wdata  in  DATAW  write data.
- i_wstrb  in  DATAW/8  byte write strobes; present only with REGBANK_WSTRB_EN.
- o_ack  out  1  one-cycle completion pulse per accepted request.
- o_err  out  1  valid with o_ack; 1 = address >= NREGS.
- o_rdata  out  DATAW  read data; valid with o_ack on reads.
- o_wr  out  NREGS  bit k pulses one cycle after a write to register k.
- o_regs  out  NREGS*DATAW  all registers flattened; register k at bits [k*DATAW +: DATAW].
- o_xor  out  1  registered XOR reduction of all register bits.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge):
  - every register = RST_VAL;
  - o_ack, o_err, o_wr and o_rdata = 0;
  - o_xor = 0.
  - Reset overrides any request in the same cycle; an access pending at reset gets no ack.
- Handshake:
  - A request is accepted on every edge with i_req = 1; there is no stall.
  - o_ack goes high on the next edge for exactly one cycle.
  - Back-to-back requests produce back-to-back acks; latency is always 1.
- Write, in range:
  - Register i_addr updates at the accept edge.
  - o_wr[i_addr] pulses together with o_ack; o_err = 0.
  - o_rdata holds its previous value.
- Read, in range:
  - o_rdata = register i_addr as it was before the accept edge; o_err = 0.
  - A read at cycle N+1 after a write at cycle N to the same address returns the new value.
- Out of range (i_addr >= NREGS, full ADDRW compare, no aliasing):
  - Writes are ignored: no register change, no o_wr pulse.
  - Reads return o_rdata = 0.
  - o_err = 1 with o_ack.
- o_regs reflects register state directly, with zero latency after the update edge.
- o_xor = XOR of all NREGS*DATAW bits as they were at the previous edge, i.e. one cycle behind o_regs.
- o_err is 0 whenever o_ack is 0.

Optional Feature:
- Macro: REGBANK_WSTRB_EN.
- Defined:
  - i_wstrb port exists; byte b of the target register is written only if i_wstrb[b] = 1.
  - o_wr still pulses when all strobes are 0 (write accepted, data unchanged).
- Undefined:
  - No i_wstrb port; every write updates the full DATAW bits.

Decomposition:
- Package regbank_pkg:
  - localparam function for strobe width (DATAW/8);
  - clog2 helper used to check NREGS <= 2**ADDRW;
  - elaboration-time assertion that DATAW % 8 == 0 when the macro is defined.
- Sub-module regbank_cell:
  - one DATAW register with synchronous active-low reset to RST_VAL, a write enable and optional byte strobes.
  - Instantiated NREGS times in a generate loop.
  - Read mux, ack/err/wr pipeline and XOR reduction live in regbank.

Test Plan:
- Reset: hold i_rst_n = 0 for 2 cycles with RST_VAL = 32'hA5A5_0000 → all o_regs words = 32'hA5A5_0000, o_ack = 0, o_xor = 0; one cycle after release o_xor = 0 (even bit count: 8 ones per word × 4).
- Write then read: write 32'hDEAD_BEEF to address 2 at cycle N, read address 2 at N+1 → o_ack high at N+1 and N+2; o_wr = 4'b0100 at N+1; o_rdata = 32'hDEAD_BEEF at N+2.
- Out of range: NREGS = 4, write 32'h1234 to address 8'h04, then read 8'h04 and 8'hFF → no o_regs change, o_wr = 0, o_err = 1 on both acks, o_rdata = 0.
- Back-to-back: 8 consecutive i_req cycles with alternating writes and reads across addresses 0..3 → 8 consecutive o_ack pulses, no gaps; each read returns the last written value.
- Strobes (macro on): register 1 = 32'h1111_1111; write 32'hFFFF_FFFF with i_wstrb = 4'b0101 → register 1 = 32'h11FF_11FF; a write with i_wstrb = 0 → data unchanged, o_wr[1] still pulses.
- Reset mid-access: assert i_rst_n = 0 in the same cycle as a write request → no ack next cycle, register = RST_VAL, o_wr = 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared helpers for the regbank register file: strobe width and parameter sanity checks.
package regbank_pkg;

    function automatic int strb_width(input int dataw);
        return dataw / 8;
    endfunction

    function automatic int clog2_int(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Every register index must be representable on the address bus.
    function automatic bit nregs_fits(input int nregs, input int addrw);
        return (nregs >= 1) && (clog2_int(nregs) <= addrw);
    endfunction

    function automatic bit dataw_byte_aligned(input int dataw);
        return (dataw % 8) == 0;
    endfunction

endpackage

// File: rtl/regbank_cell.sv
// One DATAW-wide register with synchronous active-low reset and write enable.
// Byte strobes are present only when REGBANK_WSTRB_EN is defined.
module regbank_cell
    import regbank_pkg::*;
#(
    parameter int               DATAW   = 32,
    parameter logic [DATAW-1:0] RST_VAL = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_we,
    input  logic [DATAW-1:0]            i_wdata,
`ifdef REGBANK_WSTRB_EN
    input  logic [strb_width(DATAW)-1:0] i_wstrb,
`endif
    output logic [DATAW-1:0]            o_q
);

    logic [DATAW-1:0] q_reg;
    logic [DATAW-1:0] bit_mask;

`ifdef REGBANK_WSTRB_EN
    genvar gi;
    generate
        for (gi = 0; gi < strb_width(DATAW); gi++) begin : g_mask
            assign bit_mask[gi*8 +: 8] = {8{i_wstrb[gi]}};
        end
    endgenerate
`else
    assign bit_mask = '1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            q_reg <= RST_VAL;
        end else if (i_we) begin
            q_reg <= (q_reg & ~bit_mask) | (i_wdata & bit_mask);
        end
    end

    assign o_q = q_reg;

endmodule

// File: rtl/regbank.sv
// Parametrised register bank on a req/ack bus with parallel export, write pulses and XOR reduction.
// Optional byte write strobes: define REGBANK_WSTRB_EN.
module regbank
    import regbank_pkg::*;
#(
    parameter int               DATAW   = 32,
    parameter int               NREGS   = 4,
    parameter int               ADDRW   = 8,
    parameter logic [DATAW-1:0] RST_VAL = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req,
    input  logic                         i_we,
    input  logic [ADDRW-1:0]             i_addr,
    input  logic [DATAW-1:0]             i_wdata,
`ifdef REGBANK_WSTRB_EN
    input  logic [strb_width(DATAW)-1:0] i_wstrb,
`endif
    output logic                         o_ack,
    output logic                         o_err,
    output logic [DATAW-1:0]             o_rdata,
    output logic [NREGS-1:0]             o_wr,
    output logic [NREGS*DATAW-1:0]       o_regs,
    output logic                         o_xor
);

    generate
        if (!nregs_fits(NREGS, ADDRW)) begin : g_bad_nregs
            $error("regbank: NREGS does not fit in ADDRW address bits");
        end
`ifdef REGBANK_WSTRB_EN
        if (!dataw_byte_aligned(DATAW)) begin : g_bad_dataw
            $error("regbank: DATAW must be a multiple of 8 with byte strobes");
        end
`endif
    endgenerate

    localparam logic [ADDRW:0] NREGS_LIM = (ADDRW+1)'(NREGS);

    logic [DATAW-1:0]       reg_q [NREGS];
    logic [NREGS*DATAW-1:0] regs_flat;
    logic [NREGS-1:0]       we_vec;
    logic                   in_range;
    logic                   wr_req;
    logic [DATAW-1:0]       rd_mux;

    logic                   ack_reg;
    logic                   err_reg;
    logic [NREGS-1:0]       wr_reg;
    logic [DATAW-1:0]       rdata_reg;
    logic                   xor_reg;

    // Full-width compare so out-of-range addresses never alias onto a register.
    assign in_range = ({1'b0, i_addr} < NREGS_LIM);
    assign wr_req   = i_req && i_we;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_cell
            assign we_vec[gi] = wr_req && (i_addr == ADDRW'(gi));

            regbank_cell #(
                .DATAW   (DATAW),
                .RST_VAL (RST_VAL)
            ) u_cell (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_we    (we_vec[gi]),
                .i_wdata (i_wdata),
`ifdef REGBANK_WSTRB_EN
                .i_wstrb (i_wstrb),
`endif
                .o_q     (reg_q[gi])
            );

            assign regs_flat[gi*DATAW +: DATAW] = reg_q[gi];
        end
    endgenerate

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (i_addr == ADDRW'(k)) begin
                rd_mux = reg_q[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            wr_reg    <= '0;
            rdata_reg <= '0;
            xor_reg   <= 1'b0;
        end else begin
            ack_reg <= i_req;
            err_reg <= i_req && !in_range;
            wr_reg  <= we_vec;
            xor_reg <= ^regs_flat;
            if (i_req && !i_we) begin
                rdata_reg <= rd_mux;
            end
        end
    end

    assign o_ack   = ack_reg;
    assign o_err   = err_reg;
    assign o_wr    = wr_reg;
    assign o_rdata = rdata_reg;
    assign o_regs  = regs_flat;
    assign o_xor   = xor_reg;

endmodule

// File: tb/tb_regbank.sv
// Directed self-checking bench for regbank (NREGS=4, DATAW=32, RST_VAL=32'hA5A5_0000).
`timescale 1ns/1ps
module tb_regbank;

    localparam int               DATAW   = 32;
    localparam int               NREGS   = 4;
    localparam int               ADDRW   = 8;
    localparam logic [DATAW-1:0] RST_VAL = 32'hA5A5_0000;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_req;
    logic                   i_we;
    logic [ADDRW-1:0]       i_addr;
    logic [DATAW-1:0]       i_wdata;
`ifdef REGBANK_WSTRB_EN
    logic [DATAW/8-1:0]     i_wstrb;
`endif
    logic                   o_ack;
    logic                   o_err;
    logic [DATAW-1:0]       o_rdata;
    logic [NREGS-1:0]       o_wr;
    logic [NREGS*DATAW-1:0] o_regs;
    logic                   o_xor;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    regbank #(
        .DATAW   (DATAW),
        .NREGS   (NREGS),
        .ADDRW   (ADDRW),
        .RST_VAL (RST_VAL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
`ifdef REGBANK_WSTRB_EN
        .i_wstrb (i_wstrb),
`endif
        .o_ack   (o_ack),
        .o_err   (o_err),
        .o_rdata (o_rdata),
        .o_wr    (o_wr),
        .o_regs  (o_regs),
        .o_xor   (o_xor)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [ADDRW-1:0] addr,
                         input logic [DATAW-1:0] wdata);
        i_req   = req;
        i_we    = we;
        i_addr  = addr;
        i_wdata = wdata;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [DATAW-1:0] vals [4];
        logic [127:0]     regs_after_b2b;

        vals[0] = 32'h0000_0001;
        vals[1] = 32'h0000_0007;
        vals[2] = 32'h8000_0000;
        vals[3] = 32'h0F0F_0F0E;
        regs_after_b2b = {32'h0F0F_0F0E, 32'h8000_0000, 32'h0000_0007, 32'h0000_0001};

        i_rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
`ifdef REGBANK_WSTRB_EN
        i_wstrb = 4'hF;
`endif
        tick();
        tick();
        $display("reset held 2 cycles");
        check("reset_regs", 128'(o_regs), {4{RST_VAL}});
        check("reset_ack", 128'(o_ack), 128'(0));
        check("reset_err", 128'(o_err), 128'(0));
        check("reset_wr", 128'(o_wr), 128'(0));
        check("reset_rdata", 128'(o_rdata), 128'(0));
        check("reset_xor", 128'(o_xor), 128'(0));

        i_rst_n = 1'b1;
        tick();
        $display("reset released, idle cycle");
        check("post_reset_xor", 128'(o_xor), 128'(0));
        check("idle_ack", 128'(o_ack), 128'(0));

        // Write then read of register 2
        drive(1'b1, 1'b1, 8'd2, 32'hDEAD_BEEF);
        tick();
        $display("write addr 2 data deadbeef");
        check("wr2_ack", 128'(o_ack), 128'(1));
        check("wr2_err", 128'(o_err), 128'(0));
        check("wr2_wr", 128'(o_wr), 128'(4'b0100));
        check("wr2_regs", 128'(o_regs), {RST_VAL, 32'hDEAD_BEEF, RST_VAL, RST_VAL});
        check("wr2_rdata_hold", 128'(o_rdata), 128'(0));
        drive(1'b1, 1'b0, 8'd2, 32'h0);
        tick();
        $display("read addr 2");
        check("rd2_ack", 128'(o_ack), 128'(1));
        check("rd2_err", 128'(o_err), 128'(0));
        check("rd2_wr", 128'(o_wr), 128'(0));
        check("rd2_rdata", 128'(o_rdata), 128'(32'hDEAD_BEEF));

        // Out-of-range accesses
        drive(1'b1, 1'b1, 8'h04, 32'h0000_1234);
        tick();
        $display("write addr 04 (out of range)");
        check("oor_wr_ack", 128'(o_ack), 128'(1));
        check("oor_wr_err", 128'(o_err), 128'(1));
        check("oor_wr_wr", 128'(o_wr), 128'(0));
        check("oor_wr_regs", 128'(o_regs), {RST_VAL, 32'hDEAD_BEEF, RST_VAL, RST_VAL});
        drive(1'b1, 1'b0, 8'h04, 32'h0);
        tick();
        $display("read addr 04 (out of range)");
        check("oor_rd04_ack", 128'(o_ack), 128'(1));
        check("oor_rd04_err", 128'(o_err), 128'(1));
        check("oor_rd04_rdata", 128'(o_rdata), 128'(0));
        drive(1'b1, 1'b0, 8'd2, 32'h0);
        tick();
        $display("read addr 2 again");
        check("rd2b_rdata", 128'(o_rdata), 128'(32'hDEAD_BEEF));
        check("rd2b_err", 128'(o_err), 128'(0));
        drive(1'b1, 1'b0, 8'hFF, 32'h0);
        tick();
        $display("read addr ff (out of range)");
        check("oor_rdff_ack", 128'(o_ack), 128'(1));
        check("oor_rdff_err", 128'(o_err), 128'(1));
        check("oor_rdff_rdata", 128'(o_rdata), 128'(0));
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        $display("idle");
        check("idle2_ack", 128'(o_ack), 128'(0));
        check("idle2_err", 128'(o_err), 128'(0));

        // Back-to-back alternating write/read over addresses 0..3
        for (int a = 0; a < 4; a++) begin
            drive(1'b1, 1'b1, ADDRW'(a), vals[a]);
            tick();
            $display("b2b write addr %0d data %h", a, vals[a]);
            check("b2b_wr_ack", 128'(o_ack), 128'(1));
            check("b2b_wr_pulse", 128'(o_wr), 128'(4'b0001 << a));
            if (a == 3) begin
                // XOR still reflects the bank before this write: 1+3+1+8 ones
                check("b2b_xor_lag", 128'(o_xor), 128'(1));
            end
            drive(1'b1, 1'b0, ADDRW'(a), 32'h0);
            tick();
            $display("b2b read addr %0d", a);
            check("b2b_rd_ack", 128'(o_ack), 128'(1));
            check("b2b_rd_wr", 128'(o_wr), 128'(0));
            check("b2b_rd_rdata", 128'(o_rdata), 128'(vals[a]));
        end
        check("b2b_xor_final", 128'(o_xor), 128'(0));
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        $display("idle after back-to-back");
        check("b2b_idle_ack", 128'(o_ack), 128'(0));
        check("b2b_regs", 128'(o_regs), regs_after_b2b);

`ifdef REGBANK_WSTRB_EN
        drive(1'b1, 1'b1, 8'd1, 32'h1111_1111);
        i_wstrb = 4'hF;
        tick();
        $display("strobe write addr 1 data 11111111 strb f");
        drive(1'b1, 1'b1, 8'd1, 32'hFFFF_FFFF);
        i_wstrb = 4'b0101;
        tick();
        $display("strobe write addr 1 data ffffffff strb 5");
        check("strb_partial", 128'(o_regs[63:32]), 128'(32'h11FF_11FF));
        drive(1'b1, 1'b1, 8'd1, 32'h0);
        i_wstrb = 4'b0000;
        tick();
        $display("strobe write addr 1 strb 0");
        check("strb_zero_data", 128'(o_regs[63:32]), 128'(32'h11FF_11FF));
        check("strb_zero_wr", 128'(o_wr), 128'(4'b0010));
        i_wstrb = 4'hF;
`endif

        // Reset asserted in the same cycle as a write
        i_rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'd1, 32'hFFFF_FFFF);
        tick();
        $display("reset with pending write addr 1");
        check("rstw_ack", 128'(o_ack), 128'(0));
        check("rstw_wr", 128'(o_wr), 128'(0));
        check("rstw_regs", 128'(o_regs), {4{RST_VAL}});
        check("rstw_xor", 128'(o_xor), 128'(0));
        i_rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        $display("idle after reset");
        check("rstw_idle_ack", 128'(o_ack), 128'(0));
        check("rstw_idle_regs", 128'(o_regs), {4{RST_VAL}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
